// File: rtl/median_frame_ctrl.sv
// median_frame_ctrl: frame sequencer for the 3x3 median filter datapath.
// Scans the input LUT image linearly, issuing one (above, current, below)
// read triple per cycle. A token shift register tracks read-to-result
// latency so that each result word gets its output write. A stall freezes
// everything.
module median_frame_ctrl #(
    parameter int IMG_WIDTH       = 64,
    parameter int IMG_HEIGHT      = 48,
    parameter int PIXELS_PER_WORD = 4,
    parameter int LUT_ADDR_WIDTH  = 10,
    parameter int MEM_ADDR_WIDTH  = 10,
    parameter int PIPE_LATENCY    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stall,
    output logic                      rd_en,
    output logic [LUT_ADDR_WIDTH-1:0] raddr_a,
    output logic [LUT_ADDR_WIDTH-1:0] raddr_b,
    output logic [LUT_ADDR_WIDTH-1:0] raddr_c,
    output logic                      col_first,
    output logic                      col_last,
    output logic                      core_en,
    output logic                      we,
    output logic [MEM_ADDR_WIDTH-1:0] waddr,
    output logic                      busy,
    output logic                      done
);

    localparam int WPR   = IMG_WIDTH / PIXELS_PER_WORD;
    localparam int N_OUT = (IMG_HEIGHT - 2) * WPR;
    localparam int COL_W = (WPR > 1) ? $clog2(WPR) : 1;

    // Constant compare points, computed at elaboration (no runtime multiply).
    localparam logic [LUT_ADDR_WIDTH-1:0] LAST_B    = LUT_ADDR_WIDTH'((IMG_HEIGHT - 1) * WPR - 1);
    localparam logic [LUT_ADDR_WIDTH-1:0] START_A   = LUT_ADDR_WIDTH'(0);
    localparam logic [LUT_ADDR_WIDTH-1:0] START_B   = LUT_ADDR_WIDTH'(WPR);
    localparam logic [LUT_ADDR_WIDTH-1:0] START_C   = LUT_ADDR_WIDTH'(2 * WPR);
    localparam logic [MEM_ADDR_WIDTH-1:0] LAST_W    = MEM_ADDR_WIDTH'(N_OUT - 1);
    localparam logic [COL_W-1:0]          COL_LAST  = COL_W'(WPR - 1);
    localparam logic [COL_W-1:0]          COL_ZERO  = COL_W'(0);

    // Parameter legality, rejected at elaboration.
    if (IMG_HEIGHT < 3) begin : g_bad_height
        $error("median_frame_ctrl: IMG_HEIGHT must be >= 3");
    end
    if (PIXELS_PER_WORD < 1 || (IMG_WIDTH % PIXELS_PER_WORD) != 0 || WPR < 1) begin : g_bad_width
        $error("median_frame_ctrl: IMG_WIDTH must be a nonzero multiple of PIXELS_PER_WORD");
    end
    if (PIPE_LATENCY < 1) begin : g_bad_latency
        $error("median_frame_ctrl: PIPE_LATENCY must be >= 1");
    end
    if (IMG_HEIGHT * WPR > (1 << LUT_ADDR_WIDTH)) begin : g_bad_lut
        $error("median_frame_ctrl: LUT_ADDR_WIDTH too small for image");
    end
    if (N_OUT > (1 << MEM_ADDR_WIDTH)) begin : g_bad_mem
        $error("median_frame_ctrl: MEM_ADDR_WIDTH too small for output");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state_q,   state_d;
    logic [LUT_ADDR_WIDTH-1:0] raddr_a_q, raddr_a_d;
    logic [LUT_ADDR_WIDTH-1:0] raddr_b_q, raddr_b_d;
    logic [LUT_ADDR_WIDTH-1:0] raddr_c_q, raddr_c_d;
    logic [COL_W-1:0]          col_q,     col_d;
    logic [MEM_ADDR_WIDTH-1:0] waddr_q,   waddr_d;
    logic [PIPE_LATENCY-1:0]   tok_q,     tok_d;

    logic active_s;
    logic issue_s;
    logic write_s;

    // Strobe qualification: nothing moves while stalled.
    always_comb begin
        active_s = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !stall;
        issue_s  = (state_q == S_RUN) && !stall;
        write_s  = active_s && tok_q[PIPE_LATENCY-1];
    end

    // Next-state, address, column, token and write-address logic.
    always_comb begin
        state_d   = state_q;
        raddr_a_d = raddr_a_q;
        raddr_b_d = raddr_b_q;
        raddr_c_d = raddr_c_q;
        col_d     = col_q;
        waddr_d   = waddr_q;
        tok_d     = tok_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    raddr_a_d = START_A;
                    raddr_b_d = START_B;
                    raddr_c_d = START_C;
                    col_d     = COL_ZERO;
                    waddr_d   = {MEM_ADDR_WIDTH{1'b0}};
                    tok_d     = {PIPE_LATENCY{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    // Rows are contiguous, so all three pointers just step by one.
                    tok_d     = (tok_q << 1) | PIPE_LATENCY'(1'b1);
                    raddr_a_d = raddr_a_q + LUT_ADDR_WIDTH'(1);
                    raddr_b_d = raddr_b_q + LUT_ADDR_WIDTH'(1);
                    raddr_c_d = raddr_c_q + LUT_ADDR_WIDTH'(1);
                    col_d     = (col_q == COL_LAST) ? COL_ZERO : col_q + COL_W'(1);
                    if (raddr_b_q == LAST_B) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (!stall) begin
                    tok_d = tok_q << 1;
                end else begin
                    tok_d = tok_q;
                end
            end
            S_DONE: begin
                if (!stall) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A token leaving the pipe means a result word is ready to store.
        if (write_s) begin
            waddr_d = waddr_q + MEM_ADDR_WIDTH'(1);
            if (waddr_q == LAST_W) begin
                state_d = S_DONE;
            end else begin
                state_d = state_d;
            end
        end else begin
            waddr_d = waddr_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            raddr_a_q <= {LUT_ADDR_WIDTH{1'b0}};
            raddr_b_q <= {LUT_ADDR_WIDTH{1'b0}};
            raddr_c_q <= {LUT_ADDR_WIDTH{1'b0}};
            col_q     <= COL_ZERO;
            waddr_q   <= {MEM_ADDR_WIDTH{1'b0}};
            tok_q     <= {PIPE_LATENCY{1'b0}};
        end else begin
            state_q   <= state_d;
            raddr_a_q <= raddr_a_d;
            raddr_b_q <= raddr_b_d;
            raddr_c_q <= raddr_c_d;
            col_q     <= col_d;
            waddr_q   <= waddr_d;
            tok_q     <= tok_d;
        end
    end

    // Port drive: registered state qualified by the stall input.
    always_comb begin
        rd_en     = issue_s;
        raddr_a   = raddr_a_q;
        raddr_b   = raddr_b_q;
        raddr_c   = raddr_c_q;
        col_first = issue_s && (col_q == COL_ZERO);
        col_last  = issue_s && (col_q == COL_LAST);
        core_en   = active_s;
        we        = write_s;
        waddr     = waddr_q;
        busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
        done      = (state_q == S_DONE) && !stall;
    end

endmodule
